adr_wb_arbiter: RTL and testbench
=================================

Name: adr_wb_arbiter

Overview:
- Owns the single write port of the integer register file.
- Arbitrates two writeback requesters (ALU, LSU) onto that port using valid/ready handshakes. Registers the winning write.
- Keeps x0 at zero: the regfile write port has no enable, so the block writes addr 0 / data 0 on every idle cycle.
- Provides a same-cycle forwarding lookup for two read addresses, covering the write that is landing this cycle.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_LEN, 5, register address width.
- STARVE_LIMIT, 4, number of consecutive cycles ALU may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  ALU writeback request.
- alu_ready_o  out  1  ALU request accepted this cycle.
- alu_rd_i  in  REG_ADDR_LEN  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- lsu_valid_i  in  1  LSU writeback request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- lsu_rd_i  in  REG_ADDR_LEN  LSU destination register.
- lsu_data_i  in  XLEN  LSU load data.
- rf_write_addr_o  out  REG_ADDR_LEN  to regfile write address (registered).
- rf_write_data_o  out  XLEN  to regfile write data (registered).
- fwd_addr_a_i  in  REG_ADDR_LEN  read-port A address being issued.
- fwd_addr_b_i  in  REG_ADDR_LEN  read-port B address being issued.
- fwd_hit_a_o  out  1  port A must take fwd_data_a_o.
- fwd_hit_b_o  out  1  port B must take fwd_data_b_o.
- fwd_data_a_o  out  XLEN  bypass data for port A.
- fwd_data_b_o  out  XLEN  bypass data for port B.
- wb_src_o  out  2  source of the current rf_write_* value (wb_src_e).

Behaviour:
- Reset (synchronous): rf_write_addr_o=0, rf_write_data_o=0, wb_src_o=WB_NONE, starvation counter=0. During reset, alu_ready_o=0 and lsu_ready_o=0. The regfile is written with x0=0 every reset cycle.
- A request with rd==0 ("null"):
  - ready=1 in the same cycle, regardless of the other requester.
  - Does not consume the port. Does not touch the starvation counter.
  - Data is discarded.
- Non-null arbitration (combinational ready, evaluated each cycle):
  - Only LSU non-null valid: LSU granted.
  - Only ALU non-null valid: ALU granted.
  - Both non-null valid: LSU granted, unless starve_cnt == STARVE_LIMIT; in that case ALU is granted.
  - Exactly one non-null grant per cycle. The loser sees ready=0 and must hold valid/rd/data stable.
- Starvation counter:
  - Increments when ALU is non-null valid and not granted.
  - Clears when ALU is granted or ALU is not non-null valid.
  - Saturates at STARVE_LIMIT.
- Output register, latency 1:
  - On the edge after a grant: rf_write_addr_o=rd, rf_write_data_o=data, wb_src_o=source.
  - With no non-null grant: addr=0, data=0, wb_src_o=WB_NONE.
  - The regfile commits on the following edge, so handshake-to-architectural-visibility is 2 edges.
- Forwarding, combinational:
  - fwd_hit_x_o=1 iff fwd_addr_x_i != 0 and fwd_addr_x_i == rf_write_addr_o.
  - fwd_data_x_o = rf_write_data_o when hit, else 0.
  - This covers the synchronous-read/same-edge-write collision, where the regfile returns the old value.
- Simultaneous cases:
  - ALU and LSU with the same non-null rd: LSU wins first. If ALU's write follows later, the ALU value lands last; ordering is the issuer's responsibility.
  - Both rd==0: both ready=1, idle write.
- Reset asserted mid-handshake: all ready=0 that cycle, and the pending transfer is dropped.

Decomposition:
- adr_pkg contains:
  - typedef enum logic[1:0] wb_src_e {WB_NONE, WB_ALU, WB_LSU}.
  - STARVE_LIMIT default constant.
  - XLEN / REG_ADDR_LEN taken from the existing defines.
- One sub-module, adr_starve_ctr: saturating counter with inputs inc, clr, reset; output at_limit.

Test Plan:
- reset held for 3 cycles -> rf_write_addr_o=0, rf_write_data_o=0, both ready=0; 1 cycle after release, regfile x0 reads 0.
- ALU only, rd=5, data=0xDEADBEEF -> alu_ready_o=1 same cycle; next cycle rf_write_addr_o=5, data=0xDEADBEEF, wb_src_o=WB_ALU; following cycle rf_write_addr_o=0.
- ALU rd=3 and LSU rd=4 both valid continuously -> LSU granted 4 consecutive cycles, then ALU granted on the 5th; starve_cnt returns to 0.
- LSU rd=0 data=0x1234 with ALU rd=7 -> both ready=1 same cycle; next cycle rf_write_addr_o=7, and no write of 0x1234 occurs.
- rf_write_addr_o=9, data=0xCAFE0001 with fwd_addr_a_i=9, fwd_addr_b_i=0 -> fwd_hit_a_o=1, fwd_data_a_o=0xCAFE0001, fwd_hit_b_o=0.
- reset asserted in the cycle LSU rd=2 is valid -> lsu_ready_o=0; next cycle rf_write_addr_o=0, and x2 is unchanged.

Source files
------------

// File: rtl/adr_pkg.sv
// Shared types and default widths for the writeback arbiter.
package adr_pkg;

    localparam int unsigned ADR_XLEN         = 32;
    localparam int unsigned ADR_REG_ADDR_LEN = 5;
    localparam int unsigned ADR_STARVE_LIMIT = 4;

    // Source of the value currently on the regfile write port.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/adr_starve_ctr.sv
// Saturating count of consecutive cycles the ALU lost arbitration.
module adr_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment; the count holds once it reaches LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/adr_wb_arbiter.sv
// Writeback arbiter owning the single regfile write port, with x0 hold
// and same-cycle forwarding of the write that lands this cycle.
module adr_wb_arbiter
    import adr_pkg::*;
#(
    parameter int unsigned XLEN         = ADR_XLEN,
    parameter int unsigned REG_ADDR_LEN = ADR_REG_ADDR_LEN,
    parameter int unsigned STARVE_LIMIT = ADR_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    alu_valid_i,
    output logic                    alu_ready_o,
    input  logic [REG_ADDR_LEN-1:0] alu_rd_i,
    input  logic [XLEN-1:0]         alu_data_i,

    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [REG_ADDR_LEN-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]         lsu_data_i,

    output logic [REG_ADDR_LEN-1:0] rf_write_addr_o,
    output logic [XLEN-1:0]         rf_write_data_o,

    input  logic [REG_ADDR_LEN-1:0] fwd_addr_a_i,
    input  logic [REG_ADDR_LEN-1:0] fwd_addr_b_i,
    output logic                    fwd_hit_a_o,
    output logic                    fwd_hit_b_o,
    output logic [XLEN-1:0]         fwd_data_a_o,
    output logic [XLEN-1:0]         fwd_data_b_o,

    output logic [1:0]              wb_src_o
);

    logic                    alu_nn;
    logic                    lsu_nn;
    logic                    grant_alu;
    logic                    grant_lsu;
    logic                    at_limit;
    logic                    starve_inc;

    logic [REG_ADDR_LEN-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    wb_src_e                 src_q,   src_d;

    // Requests to x0 are acknowledged immediately and never use the port.
    assign alu_nn = alu_valid_i && (alu_rd_i != '0);
    assign lsu_nn = lsu_valid_i && (lsu_rd_i != '0);

    // LSU has priority unless the ALU has lost STARVE_LIMIT times in a row.
    assign grant_alu = alu_nn && (!lsu_nn || at_limit);
    assign grant_lsu = lsu_nn && !grant_alu;

    assign alu_ready_o = !reset && alu_valid_i && ((alu_rd_i == '0) || grant_alu);
    assign lsu_ready_o = !reset && lsu_valid_i && ((lsu_rd_i == '0) || grant_lsu);

    assign starve_inc = !reset && alu_nn && !grant_alu;

    adr_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (!starve_inc),
        .at_limit (at_limit)
    );

    // Next write-port value: the granted request, otherwise an x0 <= 0 write.
    always_comb begin
        waddr_d = '0;
        wdata_d = '0;
        src_d   = WB_NONE;
        if (grant_alu) begin
            waddr_d = alu_rd_i;
            wdata_d = alu_data_i;
            src_d   = WB_ALU;
        end else if (grant_lsu) begin
            waddr_d = lsu_rd_i;
            wdata_d = lsu_data_i;
            src_d   = WB_LSU;
        end
    end

    // Write-port register; reset drives the idle x0 write.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q <= '0;
            wdata_q <= '0;
            src_q   <= WB_NONE;
        end else begin
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            src_q   <= src_d;
        end
    end

    assign rf_write_addr_o = waddr_q;
    assign rf_write_data_o = wdata_q;
    assign wb_src_o        = 2'(src_q);

    // The regfile returns the old value when reading the address being
    // written on the same edge, so the pending write is bypassed here.
    assign fwd_hit_a_o  = (fwd_addr_a_i != '0) && (fwd_addr_a_i == waddr_q);
    assign fwd_hit_b_o  = (fwd_addr_b_i != '0) && (fwd_addr_b_i == waddr_q);
    assign fwd_data_a_o = fwd_hit_a_o ? wdata_q : '0;
    assign fwd_data_b_o = fwd_hit_b_o ? wdata_q : '0;

endmodule

// File: tb/tb_adr_wb_arbiter.sv
// Bench for adr_wb_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the arbitration rules.
module tb_adr_wb_arbiter;
    import adr_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  fwd_a, fwd_b;
    logic        hit_a, hit_b;
    logic [31:0] fdata_a, fdata_b;
    logic [1:0]  wb_src;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the write port must show after the next edge.
    logic        m_init = 1'b0;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    int          m_loss;
    logic        alu_acc = 1'b0, lsu_acc = 1'b0;

    logic a_nn, l_nn, g_a, g_l, e_ar, e_lr, e_ha, e_hb;

    always #5 clk = ~clk;

    adr_wb_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid_i     (alu_valid),
        .alu_ready_o     (alu_ready),
        .alu_rd_i        (alu_rd),
        .alu_data_i      (alu_data),
        .lsu_valid_i     (lsu_valid),
        .lsu_ready_o     (lsu_ready),
        .lsu_rd_i        (lsu_rd),
        .lsu_data_i      (lsu_data),
        .rf_write_addr_o (rf_addr),
        .rf_write_data_o (rf_data),
        .fwd_addr_a_i    (fwd_a),
        .fwd_addr_b_i    (fwd_b),
        .fwd_hit_a_o     (hit_a),
        .fwd_hit_b_o     (hit_b),
        .fwd_data_a_o    (fdata_a),
        .fwd_data_b_o    (fdata_b),
        .wb_src_o        (wb_src)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: grant rules, x0 requests, starvation, write-port latency, forwarding.
    always @(negedge clk) begin
        a_nn = alu_valid && (alu_rd != 5'd0);
        l_nn = lsu_valid && (lsu_rd != 5'd0);
        if (reset) begin
            g_a = 1'b0; g_l = 1'b0; e_ar = 1'b0; e_lr = 1'b0;
        end else begin
            g_a  = a_nn && (!l_nn || m_loss >= LIMIT);
            g_l  = l_nn && !g_a;
            e_ar = alu_valid && (alu_rd == 5'd0 || g_a);
            e_lr = lsu_valid && (lsu_rd == 5'd0 || g_l);
        end
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("lsu_ready", 32'(lsu_ready), 32'(e_lr));
        alu_acc = alu_valid && alu_ready;
        lsu_acc = lsu_valid && lsu_ready;

        if (m_init) begin
            chk("rf_addr", 32'(rf_addr), 32'(m_addr));
            chk("rf_data", rf_data, m_data);
            chk("wb_src", 32'(wb_src), 32'(m_src));
            e_ha = (fwd_a != 5'd0) && (fwd_a == m_addr);
            e_hb = (fwd_b != 5'd0) && (fwd_b == m_addr);
            chk("fwd_hit_a", 32'(hit_a), 32'(e_ha));
            chk("fwd_hit_b", 32'(hit_b), 32'(e_hb));
            chk("fwd_data_a", fdata_a, e_ha ? m_data : 32'd0);
            chk("fwd_data_b", fdata_b, e_hb ? m_data : 32'd0);
        end

        if (reset) begin
            m_addr = '0; m_data = '0; m_src = 2'(WB_NONE); m_loss = 0; m_init = 1'b1;
        end else begin
            if (g_a) begin
                m_addr = alu_rd; m_data = alu_data; m_src = 2'(WB_ALU);
            end else if (g_l) begin
                m_addr = lsu_rd; m_data = lsu_data; m_src = 2'(WB_LSU);
            end else begin
                m_addr = '0; m_data = '0; m_src = 2'(WB_NONE);
            end
            if (a_nn && !g_a) m_loss = (m_loss + 1 > LIMIT) ? LIMIT : m_loss + 1;
            else              m_loss = 0;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
        fwd_a = 5'd0; fwd_b = 5'd0;

        // Reset held three cycles with a live request.
        repeat (3) @(posedge clk);
        at_neg();
        chk("rst_addr", 32'(rf_addr), 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        cyc(); reset = 1'b0; alu_valid = 1'b0;
        at_neg();
        chk("post_rst_addr", 32'(rf_addr), 32'd0);
        chk("post_rst_data", rf_data, 32'd0);

        // ALU alone.
        cyc(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        at_neg();
        chk("alu_only_ready", 32'(alu_ready), 32'd1);
        cyc(); alu_valid = 1'b0;
        at_neg();
        chk("alu_only_addr", 32'(rf_addr), 32'd5);
        chk("alu_only_data", rf_data, 32'hDEADBEEF);
        chk("alu_only_src", 32'(wb_src), 32'(WB_ALU));
        cyc();
        at_neg();
        chk("alu_only_idle", 32'(rf_addr), 32'd0);

        // Continuous contention: four LSU wins, then the ALU is forced through.
        cyc(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB4;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk($sformatf("starve_lsu_ready%0d", i), 32'(lsu_ready), (i < 4) ? 32'd1 : 32'd0);
            chk($sformatf("starve_alu_ready%0d", i), 32'(alu_ready), (i < 4) ? 32'd0 : 32'd1);
            if (i < 4) cyc();
        end
        cyc();
        at_neg();
        chk("starve_alu_addr", 32'(rf_addr), 32'd3);
        chk("starve_cleared_lsu_wins", 32'(lsu_ready), 32'd1);
        cyc(); alu_valid = 1'b0; lsu_valid = 1'b0;
        at_neg();
        chk("starve_lsu_addr", 32'(rf_addr), 32'd4);

        // Null LSU request alongside a real ALU request.
        cyc(); lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        at_neg();
        chk("null_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("null_alu_ready", 32'(alu_ready), 32'd1);
        cyc(); lsu_valid = 1'b0; alu_valid = 1'b0;
        at_neg();
        chk("null_addr", 32'(rf_addr), 32'd7);
        chk("null_data", rf_data, 32'h77);

        // Forwarding of the landing write.
        cyc(); alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE0001;
        cyc(); alu_valid = 1'b0; fwd_a = 5'd9; fwd_b = 5'd0;
        at_neg();
        chk("fwd_hit_a_lit", 32'(hit_a), 32'd1);
        chk("fwd_data_a_lit", fdata_a, 32'hCAFE0001);
        chk("fwd_hit_b_lit", 32'(hit_b), 32'd0);
        cyc(); fwd_a = 5'd0;

        // Reset during an LSU handshake drops it.
        cyc(); reset = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        at_neg();
        chk("rst_mid_lsu_ready", 32'(lsu_ready), 32'd0);
        cyc(); reset = 1'b0; lsu_valid = 1'b0;
        at_neg();
        chk("rst_mid_addr", 32'(rf_addr), 32'd0);
        chk("rst_mid_data", rf_data, 32'd0);

        // Random traffic; a requester holds its request until accepted.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset = ($urandom_range(0, 63) == 0);
            if (!alu_valid || alu_acc) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                alu_data  = $urandom;
            end
            if (!lsu_valid || lsu_acc) begin
                lsu_valid = ($urandom_range(0, 3) != 0);
                lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                lsu_data  = $urandom;
            end
            fwd_a = 5'($urandom_range(0, 7));
            fwd_b = 5'($urandom_range(0, 7));
        end

        cyc();
        reset = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        at_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
